// File: rtl/hazard_sequencer.sv
// Load-use hazard detection, stall sequencing and taken-beq flush for the 5-stage RV32 subset core.
// Optional saturating stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_sequencer #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       ID_Op_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_BranchEq_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_rd_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             PCSrc_o,
  output logic             NoOp_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned STALL_W = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STALL
  } state_t;

  state_t             state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;

  logic use_rs1, use_rs2, hazard, taken;
  logic pc_write, ifid_write, ifid_flush, pc_src, no_op;

  // Which source registers the ID instruction really reads
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (ID_Op_i)
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I, OP_LOAD: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                  ((use_rs1 && (ID_rs1_i == EX_rd_i)) ||
                   (use_rs2 && (ID_rs2_i == EX_rd_i)));
  assign taken  = (ID_Op_i == OP_BRANCH) && ID_BranchEq_i;

  // Next state and pipeline controls; defaults are the bubble / idle values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    pc_src     = 1'b0;
    no_op      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (!hazard) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          no_op      = 1'b0;
          pc_src     = taken;
          ifid_flush = taken;
        end
        if (!start_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (hazard && (STALL_CYCLES > 1)) begin
          state_d = S_STALL;
          cnt_d   = STALL_W'(STALL_CYCLES - 1);
        end
      end
      S_STALL: begin
        if (!start_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STALL_W'(1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - STALL_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Controls must act in the same cycle the hazard or branch is seen, so they follow state combinationally
  assign PCWrite_o   = pc_write;
  assign IFIDWrite_o = ifid_write;
  assign IFIDFlush_o = ifid_flush;
  assign PCSrc_o     = pc_src;
  assign NoOp_o      = no_op;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; only reset clears them
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (no_op && (state_q != S_IDLE) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: one DUT with 1 bubble per hazard, one with 3.
// Directed scenarios followed by randomized traffic against a bubbles-remaining reference model.
module tb_hazard_sequencer;

  localparam int unsigned CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [6:0] op;
  logic [4:0] rs1, rs2, ex_rd;
  logic       beq_eq, ex_mr;

  logic pcw1, ifw1, fl1, ps1, no1;
  logic pcw3, ifw3, fl3, ps3, no3;
  logic [CNT_W-1:0] sc1, fc1, sc3, fc3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.STALL_CYCLES(1), .CNT_W(CNT_W)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .ID_Op_i(op), .ID_rs1_i(rs1),
    .ID_rs2_i(rs2), .ID_BranchEq_i(beq_eq), .EX_MemRead_i(ex_mr), .EX_rd_i(ex_rd),
    .PCWrite_o(pcw1), .IFIDWrite_o(ifw1), .IFIDFlush_o(fl1), .PCSrc_o(ps1),
    .NoOp_o(no1), .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  hazard_sequencer #(.STALL_CYCLES(3), .CNT_W(CNT_W)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .ID_Op_i(op), .ID_rs1_i(rs1),
    .ID_rs2_i(rs2), .ID_BranchEq_i(beq_eq), .EX_MemRead_i(ex_mr), .EX_rd_i(ex_rd),
    .PCWrite_o(pcw3), .IFIDWrite_o(ifw3), .IFIDFlush_o(fl3), .PCSrc_o(ps3),
    .NoOp_o(no3), .stall_cnt_o(sc3), .flush_cnt_o(fc3));

  // Output vectors are {PCWrite, IFIDWrite, IFIDFlush, PCSrc, NoOp}
  localparam logic [4:0] IDLE_O = 5'b00001;
  localparam logic [4:0] BUBL_O = 5'b00001;
  localparam logic [4:0] RUN_O  = 5'b11000;
  localparam logic [4:0] TAKE_O = 5'b11110;

  function automatic logic [4:0] o1();
    return {pcw1, ifw1, fl1, ps1, no1};
  endfunction
  function automatic logic [4:0] o3();
    return {pcw3, ifw3, fl3, ps3, no3};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    op = 7'b0010011; rs1 = 5'd0; rs2 = 5'd0; beq_eq = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0;
  endtask

  task automatic set_load_use();
    op = 7'b0110011; rs1 = 5'd5; rs2 = 5'd7; beq_eq = 1'b0; ex_mr = 1'b1; ex_rd = 5'd5;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; set_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (o1() !== IDLE_O) begin n_err++; $display("FAIL reset_dut1: got %b want %b", o1(), IDLE_O); end
    n_cmp++; if (o3() !== IDLE_O) begin n_err++; $display("FAIL reset_dut3: got %b want %b", o3(), IDLE_O); end
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    @(negedge clk);
    n_cmp++; if (o1() !== IDLE_O) begin n_err++; $display("FAIL idle_before_edge: got %b want %b", o1(), IDLE_O); end
    tick();
    @(negedge clk);
    n_cmp++; if (o1() !== RUN_O) begin n_err++; $display("FAIL start_run1: got %b want %b", o1(), RUN_O); end
    n_cmp++; if (o3() !== RUN_O) begin n_err++; $display("FAIL start_run3: got %b want %b", o3(), RUN_O); end
    tick();
  endtask

  task automatic test_load_use();
    set_load_use();
    @(negedge clk);
    n_cmp++; if (o1() !== BUBL_O) begin n_err++; $display("FAIL load_use_bubble: got %b want %b", o1(), BUBL_O); end
    tick();
    set_nop();
    @(negedge clk);
    n_cmp++; if (o1() !== RUN_O) begin n_err++; $display("FAIL load_use_resume: got %b want %b", o1(), RUN_O); end
    repeat (3) tick();
  endtask

  task automatic test_no_false_stall();
    op = 7'b0010011; rs1 = 5'd0; rs2 = 5'd5; ex_mr = 1'b1; ex_rd = 5'd5;
    @(negedge clk);
    n_cmp++; if (o1() !== RUN_O) begin n_err++; $display("FAIL addi_rs2_unused: got %b want %b", o1(), RUN_O); end
    tick();
    op = 7'b0110011; rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
    @(negedge clk);
    n_cmp++; if (o1() !== RUN_O) begin n_err++; $display("FAIL rd_x0: got %b want %b", o1(), RUN_O); end
    tick();
    op = 7'b0000011; rs1 = 5'd1; rs2 = 5'd5; ex_rd = 5'd5;
    @(negedge clk);
    n_cmp++; if (o1() !== RUN_O) begin n_err++; $display("FAIL lw_rs2_unused: got %b want %b", o1(), RUN_O); end
    tick();
    op = 7'b0100011; rs1 = 5'd1; rs2 = 5'd5; ex_rd = 5'd5;
    @(negedge clk);
    n_cmp++; if (o1() !== BUBL_O) begin n_err++; $display("FAIL sw_rs2_hazard: got %b want %b", o1(), BUBL_O); end
    tick();
    set_nop();
    repeat (3) tick();
  endtask

  task automatic test_branch_hazard();
    op = 7'b1100011; rs1 = 5'd5; rs2 = 5'd8; beq_eq = 1'b1; ex_mr = 1'b1; ex_rd = 5'd5;
    @(negedge clk);
    n_cmp++; if (o1() !== BUBL_O) begin n_err++; $display("FAIL beq_hazard_first: got %b want %b", o1(), BUBL_O); end
    tick();
    ex_mr = 1'b0; ex_rd = 5'd0;
    @(negedge clk);
    n_cmp++; if (o1() !== TAKE_O) begin n_err++; $display("FAIL beq_after_stall: got %b want %b", o1(), TAKE_O); end
    tick();
    set_nop();
    repeat (3) tick();
  endtask

  task automatic test_stall3_and_async_reset();
    set_load_use();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o3() !== ((i < 3) ? BUBL_O : RUN_O)) begin
        n_err++; $display("FAIL stall3_cycle%0d: got %b want %b", i, o3(), (i < 3) ? BUBL_O : RUN_O);
      end
      tick();
      set_nop();
    end
    set_load_use();
    @(negedge clk);
    n_cmp++; if (o3() !== BUBL_O) begin n_err++; $display("FAIL stall3_again: got %b want %b", o3(), BUBL_O); end
    tick();
    set_nop();
    #1;
    n_cmp++; if (o1() !== RUN_O) begin n_err++; $display("FAIL pre_reset_dut1: got %b want %b", o1(), RUN_O); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (o1() !== IDLE_O) begin n_err++; $display("FAIL async_reset_dut1: got %b want %b", o1(), IDLE_O); end
    n_cmp++; if (o3() !== IDLE_O) begin n_err++; $display("FAIL async_reset_dut3: got %b want %b", o3(), IDLE_O); end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (o3() !== RUN_O) begin n_err++; $display("FAIL no_resume%0d: got %b want %b", i, o3(), RUN_O); end
      tick();
    end
  endtask

  task automatic test_start_drop();
    set_load_use();
    tick();
    set_nop();
    start = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (o3() !== IDLE_O) begin n_err++; $display("FAIL start_drop_idle: got %b want %b", o3(), IDLE_O); end
    start = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (o3() !== RUN_O) begin n_err++; $display("FAIL start_drop_no_resume: got %b want %b", o3(), RUN_O); end
    tick();
  endtask

  task automatic test_perf();
    rst_n = 1'b0; start = 1'b0; set_nop();
    repeat (2) tick();
    rst_n = 1'b1; start = 1'b1;
    tick();
    // Second load-use lands while dut3 is still stalling, so dut3 must not re-sample it
    set_load_use(); tick();
    set_nop();      tick();
    set_load_use(); tick();
    set_nop();      repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      op = 7'b1100011; rs1 = 5'd2; rs2 = 5'd3; beq_eq = 1'b1;
      tick();
      set_nop();
      tick();
    end
    @(negedge clk);
    n_cmp++; if (sc1 !== (PERF ? 32'd2 : 32'd0)) begin n_err++; $display("FAIL perf_stall1: got %0d want %0d", sc1, PERF ? 2 : 0); end
    n_cmp++; if (fc1 !== (PERF ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL perf_flush1: got %0d want %0d", fc1, PERF ? 3 : 0); end
    n_cmp++; if (sc3 !== (PERF ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL perf_stall3: got %0d want %0d", sc3, PERF ? 3 : 0); end
    n_cmp++; if (fc3 !== (PERF ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL perf_flush3: got %0d want %0d", fc3, PERF ? 3 : 0); end
    tick();
  endtask

  // Reference model: a running flag plus the number of bubbles still owed
  function automatic bit ref_hazard(logic [6:0] o, logic [4:0] a, logic [4:0] b, logic mr, logic [4:0] rd);
    bit r1, r2;
    r1 = o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    r2 = o inside {7'b0110011, 7'b0100011, 7'b1100011};
    return mr && (rd != 0) && ((r1 && a == rd) || (r2 && b == rd));
  endfunction

  function automatic logic [4:0] ref_out(bit run, int bub, bit hz, bit tk);
    if (!run || bub > 0 || hz) return 5'b00001;
    return {2'b11, tk, tk, 1'b0};
  endfunction

  task automatic test_random();
    logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b1101111};
    int          nbub [2] = '{1, 3};
    bit          run  [2];
    int          bub  [2];
    int unsigned scnt [2];
    int unsigned fcnt [2];
    logic [4:0]  exp  [2];
    logic [4:0]  obs;
    logic [31:0] osc, ofc;
    bit hz, tk;
    rst_n = 1'b0; start = 1'b0; set_nop();
    tick();
    for (int d = 0; d < 2; d++) begin run[d] = 0; bub[d] = 0; scnt[d] = 0; fcnt[d] = 0; end
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      start  = ($urandom_range(0, 11) != 0);
      op     = ops[$urandom_range(0, 6)];
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      ex_mr  = 1'($urandom_range(0, 1));
      beq_eq = 1'($urandom_range(0, 1));
      if (!rst_n)
        for (int d = 0; d < 2; d++) begin run[d] = 0; bub[d] = 0; scnt[d] = 0; fcnt[d] = 0; end
      hz = ref_hazard(op, rs1, rs2, ex_mr, ex_rd);
      tk = (op == 7'b1100011) && beq_eq;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp[d] = ref_out(run[d], bub[d], hz, tk);
        obs = (d == 0) ? o1() : o3();
        osc = (d == 0) ? sc1 : sc3;
        ofc = (d == 0) ? fc1 : fc3;
        n_cmp++;
        if (obs !== exp[d]) begin
          n_err++; $display("FAIL rand_out n=%0d cyc=%0d: got %b want %b", nbub[d], i, obs, exp[d]);
        end
        n_cmp++;
        if (osc !== (PERF ? scnt[d] : 32'd0) || ofc !== (PERF ? fcnt[d] : 32'd0)) begin
          n_err++; $display("FAIL rand_cnt n=%0d cyc=%0d: got %0d/%0d want %0d/%0d", nbub[d], i,
                            osc, ofc, PERF ? scnt[d] : 0, PERF ? fcnt[d] : 0);
        end
      end
      @(posedge clk);
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          if (run[d] && exp[d][0]) scnt[d]++;
          if (exp[d][2]) fcnt[d]++;
          if (!run[d]) run[d] = start;
          else if (!start) begin run[d] = 0; bub[d] = 0; end
          else if (bub[d] > 0) bub[d]--;
          else if (hz) bub[d] = nbub[d] - 1;
        end
      end
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch_hazard();
    test_stall3_and_async_reset();
    test_start_drop();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control block for the 5-stage RV32 subset core (add/addi/srai/lw/sw/beq).
- Sits beside the ID stage, next to the immediate generator and register file.
- Decodes which source registers the ID instruction actually reads and detects load-use hazards against EX.
- Sequences multi-cycle stalls with an FSM and flushes IF/ID on taken beq.
- Gates the whole pipeline until start_i.

Parameters:
- STALL_CYCLES, 1, number of bubble cycles inserted per load-use hazard (legal range 1..7).
- CNT_W, 32, width of performance counters (used only with HAZARD_PERF_EN).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- start_i  input  1  level; pipeline may run while high.
- ID_Op_i  input  7  opcode of the instruction in IF/ID.
- ID_rs1_i  input  5  rs1 field of the ID instruction.
- ID_rs2_i  input  5  rs2 field of the ID instruction.
- ID_BranchEq_i  input  1  register comparator result in ID (rs1 data == rs2 data).
- EX_MemRead_i  input  1  ID/EX instruction is a load.
- EX_rd_i  input  5  destination register of the ID/EX instruction.
- PCWrite_o  output  1  PC update enable.
- IFIDWrite_o  output  1  IF/ID register update enable.
- IFIDFlush_o  output  1  clear IF/ID to NOP on the next edge.
- PCSrc_o  output  1  1 selects the branch target for the PC.
- NoOp_o  output  1  zero the control bits entering ID/EX (bubble).
- stall_cnt_o  output  CNT_W  stall cycles inserted.
- flush_cnt_o  output  CNT_W  taken branches.

Behaviour:
- States: IDLE, RUN, STALL. Reset (rst_i=0, any time, asynchronously):
  - state=IDLE, counter=0, perf counters=0.
  - Outputs: PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0, PCSrc_o=0, NoOp_o=1.
- IDLE:
  - Outputs as in reset.
  - start_i=1 at an edge -> RUN.
- Source-use decode (combinational):
  - use_rs1 for Op 0110011, 0010011, 0000011, 0100011, 1100011.
  - use_rs2 for Op 0110011, 0100011, 1100011.
  - Any other opcode uses neither.
- hazard = EX_MemRead_i & EX_rd_i!=0 & ((use_rs1 & rs1==EX_rd_i) | (use_rs2 & rs2==EX_rd_i)).
- RUN, no hazard:
  - PCWrite_o=1, IFIDWrite_o=1, NoOp_o=0.
  - taken = (Op==1100011) & ID_BranchEq_i. PCSrc_o=taken, IFIDFlush_o=taken, both in the same cycle.
- RUN, hazard:
  - Combinationally: PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1.
  - Branch outputs forced 0; hazard has priority over a taken beq, and the beq is re-evaluated after the stall.
  - Next state: STALL if STALL_CYCLES>1 with counter=STALL_CYCLES-1; otherwise stay in RUN.
- STALL:
  - Outputs as in RUN-with-hazard.
  - Counter decrements each cycle; at counter==1 -> RUN.
  - The hazard is not re-sampled inside STALL.
- Total bubbles per hazard = STALL_CYCLES exactly.
- start_i dropping:
  - RUN or STALL with start_i=0 -> IDLE at the next edge; counter cleared.
  - An interrupted stall is not resumed.
- Back-to-back loads: every hazard detected in RUN starts a fresh stall. No merging.
- rd=x0 never causes a stall.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt_o increments every cycle NoOp_o=1 while state!=IDLE.
  - flush_cnt_o increments every cycle IFIDFlush_o=1.
  - Both saturate at all-ones and clear only on reset.
- Undefined: both ports tied to 0; no counter flops synthesized.

Test Plan:
- Reset then start: rst_i=0 for 2 cycles, start_i=0 -> NoOp_o=1, PCWrite_o=0. Raise start_i -> RUN next cycle, PCWrite_o=1, NoOp_o=0.
- Load-use, STALL_CYCLES=1: EX lw x5 (MemRead=1, rd=5); ID add x6,x5,x7 (Op 0110011, rs1=5) -> exactly 1 cycle PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1, then normal.
- No false stall:
  - ID addi x6,x0,4 with rs2 field=5, EX rd=5 load -> no stall (rs2 unused).
  - EX rd=0 with MemRead=1 -> no stall.
- Hazard vs branch: ID beq x5,x8 with ID_BranchEq_i=1, EX lw x5 -> stall first with PCSrc_o=0. Next cycle (EX bubble) -> PCSrc_o=1, IFIDFlush_o=1.
- STALL_CYCLES=3, with a mid-stall reset:
  - Hazard -> 3 consecutive bubble cycles.
  - Repeat the hazard and drop rst_i during the 2nd bubble -> outputs go to reset values immediately (asynchronously).
  - After release with start_i=1 -> RUN, no resumed stall.
- HAZARD_PERF_EN with STALL_CYCLES=1: 2 load-use hazards and 3 taken beq -> stall_cnt_o=2, flush_cnt_o=3. Without the macro both read 0.
